// File: rtl/fpga_gpu_pkg.sv
// ---------------------------------------------------------------------------
// fpga_gpu_pkg
// Shared definitions for the FMA result path.
//   DEF_LINE_WIDTH : bits per assembled result line (2 FMAs x 3 phrases x 16 b)
//   DEF_ADDR_WIDTH : result BRAM line-address bits
//   DEF_FIFO_DEPTH : default depth of the line FIFO in front of the BRAM
//   line_t         : one result line at the default width
//   writer_state_t : job state of the line writer
// ---------------------------------------------------------------------------
package fpga_gpu_pkg;

  localparam int DEF_LINE_WIDTH = 96;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [DEF_LINE_WIDTH-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } writer_state_t;

endpackage : fpga_gpu_pkg

// File: rtl/line_fifo.sv
// ---------------------------------------------------------------------------
// line_fifo
// Small synchronous FIFO holding result lines between the write buffer and
// the result BRAM. The head entry is visible combinationally on dout_out so
// the consumer can pop and use it in the same cycle.
//
// Ports:
//   clk_in    : clock
//   rst_in    : synchronous, active-low reset (flushes pointers/occupancy)
//   push_in   : write din_in at the tail (ignored when full)
//   din_in    : line to store
//   pop_in    : drop the head entry (ignored when empty)
//   dout_out  : current head entry
//   full_out  : DEPTH entries stored
//   empty_out : no entries stored
// ---------------------------------------------------------------------------
module line_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] din_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] dout_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_out  = (count_q == CNT_MAX);
  assign empty_out = (count_q == '0);
  assign dout_out  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_in && !full_out;
    do_pop   = pop_in && !empty_out;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap for free.
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: stale entries are unreachable once the pointers
  // are cleared, so only the control state needs the reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_in) begin
        if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
          mem_q[gi] <= din_in;
        end
      end
    end
  endgenerate

endmodule : line_fifo

// File: rtl/fma_line_writer.sv
// ---------------------------------------------------------------------------
// fma_line_writer
// Accepts assembled result lines from the FMA write buffer, buffers them in
// a small FIFO and drains them into the result BRAM one write per cycle at
// consecutive addresses from a programmed base. A job is delimited by a
// programmed line count; done_out pulses once when the job completes.
//
// Ports:
//   clk_in         : clock
//   rst_in         : synchronous, active-low reset (abandons any job)
//   start_in       : one-cycle job start, honoured only in IDLE
//   base_addr_in   : first BRAM address of the job (latched on start)
//   line_count_in  : number of lines in the job (latched on start)
//   line_in        : assembled line from the write buffer
//   line_valid_in  : line_in valid
//   line_ready_out : line_in is accepted this cycle when valid
//   bram_addr_out  : BRAM write address (holds last value when idle)
//   bram_din_out   : BRAM write data (holds last value when idle)
//   bram_we_out    : BRAM write enable
//   busy_out       : job in progress
//   done_out       : one-cycle pulse at job end
// ---------------------------------------------------------------------------
module fma_line_writer
  import fpga_gpu_pkg::*;
#(
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [ADDR_WIDTH:0]   line_count_in,
  input  logic [LINE_WIDTH-1:0] line_in,
  input  logic                  line_valid_in,
  output logic                  line_ready_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [LINE_WIDTH-1:0] bram_din_out,
  output logic                  bram_we_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  writer_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  // Counters are one bit wider than the address so a full-BRAM job fits.
  logic [ADDR_WIDTH:0]   target_q, target_d;
  logic [ADDR_WIDTH:0]   accepted_q, accepted_d;
  logic [ADDR_WIDTH:0]   written_q, written_d;

  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [LINE_WIDTH-1:0] bram_din_q, bram_din_d;
  logic                  bram_we_q, bram_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LINE_WIDTH-1:0] fifo_dout;

  // Ready depends on registered state only, never on line_valid_in. When
  // the FIFO is full there is no bypass: the pop frees a slot and ready
  // rises on the following cycle.
  assign line_ready_out = (state_q == WRITE) && !fifo_full && (accepted_q < target_q);
  assign fifo_push      = line_valid_in && line_ready_out;
  assign fifo_pop       = (state_q == WRITE) && !fifo_empty;

  line_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LINE_WIDTH)
  ) u_line_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (fifo_push),
    .din_in    (line_in),
    .pop_in    (fifo_pop),
    .dout_out  (fifo_dout),
    .full_out  (fifo_full),
    .empty_out (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    target_d    = target_q;
    accepted_d  = accepted_q;
    written_d   = written_q;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    bram_we_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          wr_addr_d  = base_addr_in;
          target_d   = line_count_in;
          accepted_d = '0;
          written_d  = '0;
          state_d    = (line_count_in == '0) ? DONE : WRITE;
        end
      end

      WRITE: begin
        if (fifo_push) begin
          accepted_d = accepted_q + CNT_ONE;
        end
        if (fifo_pop) begin
          bram_we_d   = 1'b1;
          bram_addr_d = wr_addr_q;
          bram_din_d  = fifo_dout;
          // Wraps modulo the BRAM size; range checking belongs upstream.
          wr_addr_d   = wr_addr_q + ADDR_ONE;
          written_d   = written_q + CNT_ONE;
        end
        // Evaluated on the registered count, so DONE follows the cycle in
        // which the last write was presented to the BRAM.
        if (written_q == target_q) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      target_q    <= '0;
      accepted_q  <= '0;
      written_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      target_q    <= target_d;
      accepted_q  <= accepted_d;
      written_q   <= written_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_we_q   <= bram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bram_addr_out = bram_addr_q;
  assign bram_din_out  = bram_din_q;
  assign bram_we_out   = bram_we_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;

endmodule : fma_line_writer

// File: tb/tb_fma_line_writer.sv
// ---------------------------------------------------------------------------
// tb_fma_line_writer
// Drives jobs with randomized valid patterns. The reference model is the job
// itself: line i of a job must land at (base + i) mod 512, each accepted
// line is written on the cycle after the edge at which the FIFO holds it,
// ready is high only while the job still needs lines and fewer than four are
// buffered, and done pulses once on the cycle after the last write.
// ---------------------------------------------------------------------------
module tb_fma_line_writer;

  localparam int LW    = 96;
  localparam int AW    = 9;
  localparam int DEPTH = 4;
  localparam int NADDR = 1 << AW;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [AW:0]   line_count_in;
  logic [LW-1:0] line_in;
  logic          line_valid_in;
  logic          line_ready_out;
  logic [AW-1:0] bram_addr_out;
  logic [LW-1:0] bram_din_out;
  logic          bram_we_out;
  logic          busy_out;
  logic          done_out;

  always #5 clk_in = ~clk_in;

  fma_line_writer #(
    .LINE_WIDTH (LW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .base_addr_in   (base_addr_in),
    .line_count_in  (line_count_in),
    .line_in        (line_in),
    .line_valid_in  (line_valid_in),
    .line_ready_out (line_ready_out),
    .bram_addr_out  (bram_addr_out),
    .bram_din_out   (bram_din_out),
    .bram_we_out    (bram_we_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Run one job and compare every cycle against the job-level model.
  task automatic run_job(input int base, input int count, input int valid_pct,
                         input bit pattern, input bit poke_start);
    logic [LW-1:0] lines[$];
    int  acc      = 0;
    int  wr       = 0;
    int  acc_prev = 0;
    int  cyc      = 0;
    int  budget;
    int  exp_addr;
    bit  fire;
    bit  exp_we;
    bit  exp_ready;

    lines = {};
    for (int i = 0; i < count; i++) begin
      if (pattern) lines.push_back(LW'(32'hA + i));
      else         lines.push_back({$urandom(), $urandom(), $urandom()});
    end

    base_addr_in  = AW'(base);
    line_count_in = (AW + 1)'(count);
    line_valid_in = 1'b0;
    start_in      = 1'b1;
    step();
    start_in = 1'b0;

    if (count == 0) begin
      check_val("zero_busy", busy_out, 0);
      check_val("zero_done", done_out, 1);
      check_val("zero_we", bram_we_out, 0);
      check_val("zero_ready", line_ready_out, 0);
      step();
      check_val("zero_done_once", done_out, 0);
      check_val("zero_busy_after", busy_out, 0);
      check_val("zero_we_after", bram_we_out, 0);
      $display("job base=0x%03h count=%0d zero-length checked", base, count);
      return;
    end

    budget = count * 25 + 50;
    while (wr < count && cyc < budget) begin
      check_val("busy", busy_out, 1);
      check_val("done_early", done_out, 0);
      // A write is due whenever the FIFO held something before this edge.
      exp_we = (acc_prev - wr) > 0;
      check_val("we", bram_we_out, exp_we);
      if (bram_we_out) begin
        if (wr < count) begin
          exp_addr = (base + wr) % NADDR;
          check_val("addr", bram_addr_out, exp_addr);
          check_val("data", bram_din_out, lines[wr]);
        end
        wr++;
      end
      exp_ready = (acc < count) && ((acc - wr) < DEPTH);
      check_val("ready", line_ready_out, exp_ready);

      line_valid_in = ($urandom_range(99) < valid_pct);
      if (line_valid_in && acc < count) line_in = lines[acc];
      else                              line_in = {$urandom(), $urandom(), $urandom()};
      if (poke_start && cyc == 3) begin
        start_in      = 1'b1;
        base_addr_in  = AW'(9'h100);
        line_count_in = (AW + 1)'(5);
      end
      fire     = line_valid_in && line_ready_out;
      acc_prev = acc;
      step();
      cyc++;
      start_in = 1'b0;
      if (fire) acc++;
    end

    if (wr < count) check_val("job_timeout_writes", wr, count);
    check_val("accepted_total", acc, count);
    check_val("done_pulse", done_out, 1);
    check_val("busy_end", busy_out, 0);
    check_val("we_end", bram_we_out, 0);
    check_val("ready_end", line_ready_out, 0);

    line_valid_in = 1'b0;
    // A start presented while in DONE must be ignored as well.
    if (poke_start) begin
      start_in      = 1'b1;
      base_addr_in  = AW'(9'h100);
      line_count_in = (AW + 1)'(5);
    end
    step();
    start_in = 1'b0;
    check_val("done_once", done_out, 0);
    check_val("idle_busy", busy_out, 0);
    check_val("idle_we", bram_we_out, 0);
    $display("job base=0x%03h count=%0d valid%%=%0d writes=%0d cycles=%0d",
             base, count, valid_pct, wr, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in        = 1'b0;
    start_in      = 1'b0;
    base_addr_in  = '0;
    line_count_in = '0;
    line_in       = '0;
    line_valid_in = 1'b0;
    step();
    step();
    check_val("rst_ready", line_ready_out, 0);
    check_val("rst_we", bram_we_out, 0);
    check_val("rst_addr", bram_addr_out, 0);
    check_val("rst_din", bram_din_out, 0);
    check_val("rst_busy", busy_out, 0);
    check_val("rst_done", done_out, 0);
    rst_in = 1'b1;
    step();
    check_val("idle_ready", line_ready_out, 0);
    $display("reset state checked");

    // Reset in the middle of a job.
    base_addr_in  = AW'(9'h010);
    line_count_in = (AW + 1)'(3);
    start_in      = 1'b1;
    step();
    start_in = 1'b0;
    check_val("midrst_busy", busy_out, 1);
    line_valid_in = 1'b1;
    line_in       = LW'(96'h111);
    step();
    line_in = LW'(96'h222);
    step();
    line_valid_in = 1'b0;
    rst_in        = 1'b0;
    step();
    rst_in = 1'b1;
    check_val("midrst_we", bram_we_out, 0);
    check_val("midrst_busy0", busy_out, 0);
    check_val("midrst_done", done_out, 0);
    check_val("midrst_ready", line_ready_out, 0);
    check_val("midrst_addr", bram_addr_out, 0);
    check_val("midrst_din", bram_din_out, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("midrst_quiet_we", bram_we_out, 0);
      check_val("midrst_quiet_done", done_out, 0);
      check_val("midrst_quiet_busy", busy_out, 0);
    end
    $display("reset mid-job checked");

    run_job(32'h020, 4, 100, 1'b1, 1'b0);   // back-to-back lines 0xA..0xD
    run_job(32'h000, 8, 100, 1'b0, 1'b0);   // sustained 8-line job
    run_job(32'h055, 0, 100, 1'b0, 1'b0);   // zero-length job
    run_job(32'h1FE, 4, 100, 1'b0, 1'b0);   // address wrap
    run_job(32'h040, 6, 60, 1'b0, 1'b1);    // start while busy / in DONE
    for (int j = 0; j < 12; j++) begin
      run_job($urandom_range(NADDR - 1), $urandom_range(20), $urandom_range(30, 100), 1'b0, 1'b0);
    end
    run_job(32'h123, NADDR, 100, 1'b0, 1'b0); // full-BRAM job, count = 2^AW

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fma_line_writer
